// File: rtl/icap_reg_access_if.sv
// Request/response bus between fabric logic and the ICAPE2 register-access controller.
// The master issues single-register reads or writes; the slave answers with a one-cycle completion pulse.
interface icap_reg_access_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [4:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/icap_reg_access.sv
// ICAPE2 (X32) initiator: expands single-register read/write requests into the full
// sync / type-1 / desync packet sequence, including the read-direction turnaround.
module icap_reg_access #(
    parameter int STARTUP_CYCLES = 2048,
    parameter int READ_LAT       = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    icap_reg_access_if.slave    bus,
    output logic                icap_csib,
    output logic                icap_rdwrb,
    output logic [31:0]         icap_i,
    input  logic [31:0]         icap_o
);

    typedef enum logic [3:0] {
        S_STARTUP, S_IDLE, S_SEQ, S_TURN_A, S_TURN_B,
        S_RD_WIN, S_TURN_C, S_TURN_D, S_DESYNC, S_DONE
    } state_t;

    // One counter serves startup, packet index and read window; 4 bits cover the packet phases.
    localparam int CW = ($clog2(STARTUP_CYCLES + 1) > 4) ? $clog2(STARTUP_CYCLES + 1) : 4;

    localparam logic [31:0] W_DUMMY   = 32'hFFFF_FFFF;
    localparam logic [31:0] W_SYNC    = 32'hAA99_5566;
    localparam logic [31:0] W_NOOP    = 32'h2000_0000;
    localparam logic [31:0] W_CMD_HDR = 32'h3000_8001;
    localparam logic [31:0] W_DESYNC  = 32'h0000_000D;

    // ICAP expects each byte bit-reversed with byte order kept; the mapping is its own inverse.
    function automatic logic [31:0] swap(input logic [31:0] w);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            for (int j = 0; j < 8; j++)
                r[8*b + j] = w[8*b + 7 - j];
        return r;
    endfunction

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          wr_q, wr_nxt;
    logic [4:0]    addr_q, addr_nxt;
    logic [31:0]   wdata_q, wdata_nxt;
    logic          csib_nxt, rdwrb_nxt, ready_nxt, rv_nxt;
    logic [31:0]   word_nxt;

    // NOTE: every variable gets a default at the top of the block so no path leaves one unassigned (no latches).
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wr_nxt    = wr_q;
        addr_nxt  = addr_q;
        wdata_nxt = wdata_q;

        case (state)
            S_STARTUP: begin
                if (cnt == CW'(STARTUP_CYCLES)) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_IDLE: begin
                if (bus.req_valid && bus.req_ready) begin
                    state_nxt = S_SEQ;
                    cnt_nxt   = '0;
                    wr_nxt    = bus.req_write;
                    addr_nxt  = bus.req_addr;
                    wdata_nxt = bus.req_wdata;
                end
            end
            S_SEQ: begin
                if (cnt == (wr_q ? CW'(10) : CW'(5))) begin
                    state_nxt = wr_q ? S_DONE : S_TURN_A;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_TURN_A: state_nxt = S_TURN_B;
            S_TURN_B: begin
                state_nxt = S_RD_WIN;
                cnt_nxt   = '0;
            end
            S_RD_WIN: begin
                if (cnt == CW'(READ_LAT - 1)) begin
                    state_nxt = S_TURN_C;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_TURN_C: state_nxt = S_TURN_D;
            S_TURN_D: begin
                state_nxt = S_DESYNC;
                cnt_nxt   = '0;
            end
            S_DESYNC: begin
                if (cnt == CW'(3)) begin
                    state_nxt = S_DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_STARTUP;
        endcase

        // Pin values are decoded from the next state so they appear registered in the cycle they belong to.
        csib_nxt  = 1'b1;
        rdwrb_nxt = 1'b0;
        word_nxt  = W_DUMMY;
        ready_nxt = (state_nxt == S_IDLE);
        rv_nxt    = (state_nxt == S_DONE);

        case (state_nxt)
            S_SEQ: begin
                csib_nxt = 1'b0;
                case (cnt_nxt)
                    CW'(0):  word_nxt = W_DUMMY;
                    CW'(1):  word_nxt = W_SYNC;
                    CW'(3):  word_nxt = (wr_nxt ? 32'h3000_0001 : 32'h2800_0001) | {14'd0, addr_nxt, 13'd0};
                    CW'(4):  word_nxt = wr_nxt ? wdata_nxt : W_NOOP;
                    CW'(7):  word_nxt = wr_nxt ? W_CMD_HDR : W_NOOP;
                    CW'(8):  word_nxt = wr_nxt ? W_DESYNC : W_NOOP;
                    default: word_nxt = W_NOOP;
                endcase
            end
            S_TURN_B, S_TURN_C: rdwrb_nxt = 1'b1;
            S_RD_WIN: begin
                csib_nxt  = 1'b0;
                rdwrb_nxt = 1'b1;
            end
            S_DESYNC: begin
                csib_nxt = 1'b0;
                case (cnt_nxt)
                    CW'(0):  word_nxt = W_CMD_HDR;
                    CW'(1):  word_nxt = W_DESYNC;
                    default: word_nxt = W_NOOP;
                endcase
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_STARTUP;
            cnt           <= '0;
            wr_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            bus.req_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            icap_csib     <= 1'b1;
            icap_rdwrb    <= 1'b0;
            icap_i        <= W_DUMMY;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            wr_q          <= wr_nxt;
            addr_q        <= addr_nxt;
            wdata_q       <= wdata_nxt;
            bus.req_ready <= ready_nxt;
            bus.rsp_valid <= rv_nxt;
            icap_csib     <= csib_nxt;
            icap_rdwrb    <= rdwrb_nxt;
            icap_i        <= swap(word_nxt);
            if (state == S_RD_WIN && cnt == CW'(READ_LAT - 1))
                bus.rsp_rdata <= swap(icap_o);
        end
    end

endmodule

// File: tb/tb_icap_reg_access.sv
// Bench for icap_reg_access: cycle-level expected-pin timeline built from the packet rules,
// an ICAPE2 register model answering reads, a protocol watcher and directed literal checks.
module tb_icap_reg_access;
    localparam int STARTUP_CYCLES = 16;
    localparam int READ_LAT       = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        icap_csib, icap_rdwrb;
    logic [31:0] icap_i;
    logic [31:0] icap_o;

    icap_reg_access_if bus ();

    icap_reg_access #(
        .STARTUP_CYCLES(STARTUP_CYCLES),
        .READ_LAT      (READ_LAT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .icap_csib (icap_csib),
        .icap_rdwrb(icap_rdwrb),
        .icap_i    (icap_i),
        .icap_o    (icap_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int edges    = 0;

    always @(posedge clk) cyc++;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) edges = 0;
        else          edges++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %h, want %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] bswap(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = w[(i & ~7) | (7 - (i & 7))];
        return r;
    endfunction

    // ICAPE2 register contents seen by reads.
    logic [31:0] regs [32];

    // ---------------- reference timeline ----------------
    typedef struct {
        logic        csib;
        logic        rdwrb;
        logic [31:0] word;
        logic        rv;
        logic [31:0] rdata;
    } cyc_t;

    cyc_t        expq [$];
    logic [31:0] cur_rdata = 32'h0;

    function automatic void push(input logic c, input logic r, input logic [31:0] w,
                                 input logic v, input logic [31:0] d);
        cyc_t e;
        e.csib = c; e.rdwrb = r; e.word = w; e.rv = v; e.rdata = d;
        expq.push_back(e);
    endfunction

    function automatic void build(input logic wr, input logic [4:0] a, input logic [31:0] d);
        logic [31:0] ws [11];
        logic [31:0] nd;
        ws[0] = 32'hFFFFFFFF; ws[1] = 32'hAA995566; ws[2] = 32'h20000000;
        ws[3] = (wr ? 32'h30000001 : 32'h28000001) + (32'(a) << 13);
        ws[4] = wr ? d : 32'h20000000;
        ws[5] = 32'h20000000; ws[6] = 32'h20000000;
        ws[7] = 32'h30008001; ws[8] = 32'h0000000D;
        ws[9] = 32'h20000000; ws[10] = 32'h20000000;
        if (wr) begin
            for (int i = 0; i < 11; i++) push(1'b0, 1'b0, bswap(ws[i]), 1'b0, cur_rdata);
            push(1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, cur_rdata);
        end else begin
            nd = regs[a];
            for (int i = 0; i < 6; i++) push(1'b0, 1'b0, bswap(ws[i]), 1'b0, cur_rdata);
            push(1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, cur_rdata);
            push(1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, cur_rdata);
            for (int i = 0; i < READ_LAT; i++) push(1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, cur_rdata);
            push(1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, nd);
            push(1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, nd);
            for (int i = 7; i < 11; i++) push(1'b0, 1'b0, bswap(ws[i]), 1'b0, nd);
            push(1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, nd);
            cur_rdata = nd;
        end
    endfunction

    // Compare every cycle's outputs against the timeline, then accept a new request if the model is idle.
    cyc_t e;
    logic exp_ready;
    always @(negedge clk) begin
        if (!reset_n) begin
            expq.delete();
            cur_rdata = 32'h0;
        end
        exp_ready = 1'b0;
        if (expq.size() > 0) begin
            e = expq.pop_front();
        end else begin
            e = '{1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, cur_rdata};
            exp_ready = reset_n && (edges >= STARTUP_CYCLES + 1);
        end
        check("req_ready",  {31'd0, bus.req_ready}, {31'd0, exp_ready});
        check("rsp_valid",  {31'd0, bus.rsp_valid}, {31'd0, e.rv});
        check("rsp_rdata",  bus.rsp_rdata, e.rdata);
        check("icap_csib",  {31'd0, icap_csib},  {31'd0, e.csib});
        check("icap_rdwrb", {31'd0, icap_rdwrb}, {31'd0, e.rdwrb});
        check("icap_i",     icap_i, e.word);
        if (exp_ready && bus.req_valid) build(bus.req_write, bus.req_addr, bus.req_wdata);
    end

    // RDWRB may only move when CSIB is high now and was high in the previous cycle.
    logic prev_csib = 1'b1, prev_rdwrb = 1'b0;
    always @(negedge clk) begin
        if (reset_n) begin
            if (icap_rdwrb !== prev_rdwrb)
                check("proto_rdwrb_toggle", {30'd0, icap_csib, prev_csib}, 32'd3);
            if (icap_csib === 1'b1)
                check("proto_idle_word", icap_i, 32'hFFFFFFFF);
        end
        prev_csib  = icap_csib;
        prev_rdwrb = icap_rdwrb;
    end

    // ICAPE2 model: data is valid only on the READ_LAT-th read-window cycle, garbage otherwise.
    logic [4:0]  rd_addr = 5'd0;
    int          win = 0;
    logic [31:0] seen;
    always @(posedge clk) begin
        #1;
        seen = bswap(icap_i);
        if (!icap_csib && !icap_rdwrb && ((seen & 32'hFFFC1FFF) == 32'h28000001))
            rd_addr = seen[17:13];
        if (!icap_csib && icap_rdwrb) win++;
        else                          win = 0;
        icap_o = (win == READ_LAT) ? bswap(regs[rd_addr]) : $urandom;
    end

    // ---------------- stimulus ----------------
    logic [31:0] cap_i     [0:40];
    logic        cap_csib  [0:40];
    logic        cap_rdwrb [0:40];
    int          t_hs, rv_at;

    task automatic issue(input logic w, input logic [4:0] a, input logic [31:0] d,
                         input bit noise, input bit hold);
        bit got;
        @(posedge clk); #2;
        bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = a; bus.req_wdata = d;
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (bus.req_ready) got = 1'b1;
        end
        if (!got) begin
            check("handshake_timeout", {31'd0, bus.req_ready}, 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        t_hs  = cyc;
        rv_at = -1;
        for (int k = 1; k <= 40 && rv_at < 0; k++) begin
            @(posedge clk); #2;
            if (noise) begin
                bus.req_valid = 1'($urandom_range(0, 1));
                bus.req_write = 1'($urandom_range(0, 1));
                bus.req_addr  = 5'($urandom_range(0, 31));
                bus.req_wdata = $urandom;
            end else if (!hold) begin
                bus.req_valid = 1'b0;
            end
            @(negedge clk);
            cap_i[k] = icap_i; cap_csib[k] = icap_csib; cap_rdwrb[k] = icap_rdwrb;
            if (bus.rsp_valid) rv_at = k;
        end
        if (rv_at < 0) check("rsp_timeout", {31'd0, bus.rsp_valid}, 32'd1);
        if (!hold) begin
            @(posedge clk); #2;
            bus.req_valid = 1'b0;
        end
    endtask

    task automatic expect_startup(input string name);
        int rdy_at;
        rdy_at = -1;
        for (int k = 1; k <= STARTUP_CYCLES + 10 && rdy_at < 0; k++) begin
            @(negedge clk);
            if (bus.req_ready) rdy_at = k;
        end
        check(name, rdy_at, STARTUP_CYCLES + 1);
    endtask

    int t_first, rv_first;
    bit in_win;

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[12] = 32'h03651093;
        icap_o = 32'h0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = 5'd0; bus.req_wdata = 32'h0;

        // Reset values and startup length
        repeat (3) @(negedge clk);
        check("rst_csib",  {31'd0, icap_csib},  32'd1);
        check("rst_rdwrb", {31'd0, icap_rdwrb}, 32'd0);
        check("rst_icap_i", icap_i, 32'hFFFFFFFF);
        check("rst_ready", {31'd0, bus.req_ready}, 32'd0);
        check("rst_rdata", bus.rsp_rdata, 32'd0);
        #2 reset_n = 1'b1;
        expect_startup("startup_ready_cycle");

        // WBSTAR write
        issue(1'b1, 5'h10, 32'h00400000, 1'b0, 1'b0);
        check("wr_w1",  cap_i[1],  32'hFFFFFFFF);
        check("wr_w2",  cap_i[2],  32'h5599AA66);
        check("wr_w3",  cap_i[3],  32'h04000000);
        check("wr_hdr", cap_i[4],  32'h0C400080);
        check("wr_dat", cap_i[5],  32'h00020000);
        check("wr_w6",  cap_i[6],  32'h04000000);
        check("wr_w8",  cap_i[8],  32'h0C000180);
        check("wr_w9",  cap_i[9],  32'h000000B0);
        check("wr_w11", cap_i[11], 32'h04000000);
        check("wr_csib_last", {31'd0, cap_csib[11]}, 32'd0);
        check("wr_rsp_at", rv_at, 12);

        // IDCODE read
        issue(1'b0, 5'h0C, 32'h0, 1'b0, 1'b0);
        check("rd_hdr", cap_i[4], 32'h14800180);
        check("rd_turn_a", {30'd0, cap_csib[7],  cap_rdwrb[7]},  32'd2);
        check("rd_turn_b", {30'd0, cap_csib[8],  cap_rdwrb[8]},  32'd3);
        check("rd_win0",   {30'd0, cap_csib[9],  cap_rdwrb[9]},  32'd1);
        check("rd_winN",   {30'd0, cap_csib[11], cap_rdwrb[11]}, 32'd1);
        check("rd_turn_c", {30'd0, cap_csib[12], cap_rdwrb[12]}, 32'd3);
        check("rd_turn_d", {30'd0, cap_csib[13], cap_rdwrb[13]}, 32'd2);
        check("rd_desync", cap_i[14], 32'h0C000180);
        check("rd_rsp_at", rv_at, 15 + READ_LAT);
        check("rd_idcode", bus.rsp_rdata, 32'h03651093);

        // Back-to-back with req_valid held high
        issue(1'b1, 5'h04, 32'h0000000F, 1'b0, 1'b1);
        t_first  = t_hs;
        rv_first = rv_at;
        issue(1'b0, 5'h0C, 32'h0, 1'b0, 1'b0);
        check("b2b_accept_gap", t_hs - t_first, rv_first + 1);

        // Random mix with junk requests while busy
        for (int n = 0; n < 30; n++) begin
            issue(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, 1'b1, 1'b0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        // Reset during the read window
        @(posedge clk); #2;
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 5'h07;
        @(posedge clk); #2;
        bus.req_valid = 1'b0;
        in_win = 1'b0;
        for (int k = 0; k < 60 && !in_win; k++) begin
            @(negedge clk);
            if (!icap_csib && icap_rdwrb) in_win = 1'b1;
        end
        check("reached_rd_win", {31'd0, in_win}, 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("abort_csib",  {31'd0, icap_csib},  32'd1);
        check("abort_rdwrb", {31'd0, icap_rdwrb}, 32'd0);
        check("abort_valid", {31'd0, bus.rsp_valid}, 32'd0);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        expect_startup("restart_ready_cycle");
        issue(1'b0, 5'h0C, 32'h0, 1'b0, 1'b0);
        check("post_reset_idcode", bus.rsp_rdata, 32'h03651093);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
